hangman_round_ctrl: RTL and testbench
=====================================

Name: hangman_round_ctrl

Overview:
- Game-round controller for the hangman datapath.
- Latches the secret word (up to 10 ASCII letters) at new_game, then accepts one keyboard guess at a time and runs it through a per-position letter comparator.
- Accumulates the revealed-position mask and the miss count, and declares win or loss.
- Feeds the VGA draw logic (revealed letters, gallows stage) and the HEX miss display.

Parameters:
- MAX_LEN, 10, number of letter slots in the word.
- CHAR_W, 8, bits per character (ASCII).
- MAX_MISSES, 6, number of misses that ends the round as lost.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- new_game  input  1  one-cycle request to start a round.
- word_flat  input  MAX_LEN*CHAR_W  secret word; slot i is bits [i*8+7:i*8]; lowercase ASCII.
- word_len  input  4  number of valid slots, 1..MAX_LEN.
- guess_valid  input  1  guess offered this cycle.
- guess_char  input  CHAR_W  ASCII guess.
- guess_ready  output  1  controller can accept a guess this cycle.
- revealed  output  MAX_LEN  bit i = slot i has been guessed.
- miss_count  output  4  wrong guesses so far.
- hit_pulse  output  1  one cycle; the last guess matched at least one slot.
- miss_pulse  output  1  one cycle; the last guess matched no slot.
- dup_pulse  output  1  one cycle; the guess was already used and was ignored.
- game_won  output  1  level; held until new_game or reset.
- game_lost  output  1  level; held until new_game or reset.

Behaviour:
- States: IDLE, WAIT_GUESS, CHECK, UPDATE, DONE.
- On reset: state IDLE; all outputs 0; internal word, length and 26-bit used-letter mask cleared.
- Priority: reset, then new_game, then guess handling.

new_game:
- Accepted in any state.
- Latches word_flat and word_len, and clamps word_len above MAX_LEN to MAX_LEN.
- Clears revealed, miss_count, used mask, game_won, game_lost and the pulses; next state is WAIT_GUESS.
- If word_len == 0, new_game is ignored entirely.
- new_game arriving mid-CHECK/UPDATE aborts the pending guess: no pulse, no count change.

Guess acceptance:
- guess_ready = 1 only in WAIT_GUESS. A guess is accepted on a clock edge where guess_ready && guess_valid.
- Uppercase guesses (0x41-0x5A) are folded to lowercase.
- Other non-letters are dropped silently: no pulse, stay in WAIT_GUESS.
- Already-used letter: dup_pulse for one cycle, stay in WAIT_GUESS, no count change.
- New letter: latch it, set its used bit, go to CHECK.

Matching and update:
- CHECK: register match[i] = (slot i == latched char) && (i < len); go to UPDATE.
- UPDATE:
  - revealed <= revealed | match.
  - If match == 0: miss_count <= miss_count + 1 and miss_pulse; otherwise hit_pulse.
  - Next state is DONE when won or lost, else WAIT_GUESS.
- Win: (revealed | match | ~len_mask) is all ones. Sets game_won.
- Loss: miss_count + 1 == MAX_MISSES on a miss. Sets game_lost.
- Win and loss are mutually exclusive, because a hit never increments the miss count.
- Latency: guess accepted at edge k; revealed, miss_count and pulses are visible after edge k+2. guess_ready returns in the cycle after edge k+2 if the game has not ended.
- Pulses last exactly one cycle.
- miss_count saturates at MAX_MISSES and never wraps.
- DONE: guess_ready = 0; guess_valid is ignored; only new_game or reset leave DONE.
- Slots at index >= word_len never set revealed bits.

Decomposition:
- Shared package hangman_pkg holds:
  - state enum;
  - MAX_LEN, CHAR_W, MAX_MISSES;
  - ASCII constants 'a', 'z', 'A', 'Z';
  - function char_to_idx (letter to 0..25).
- One combinational sub-module, letter_match: char plus MAX_LEN slots plus len in, MAX_LEN match vector plus any-match out. Instantiated in CHECK.
- The controller owns all state.

Test Plan:
1. Word "apple" (len 5); guess 'p' → after 3 edges revealed = 0b00110, hit_pulse for 1 cycle, miss_count = 0.
2. Same word; guesses 'a','p','l','e' → after 'e' update, revealed = 0b11111, game_won = 1, guess_ready = 0; a further 'z' has no effect.
3. Word "cat"; guesses 'x','y','q','w','v','u' → miss_count steps 1..6, game_lost = 1 after the sixth, game_won stays 0.
4. Word "cat"; guess 'c' then 'C' → the second guess gives dup_pulse, miss_count = 0, revealed unchanged at 0b001.
5. Guess '5' (0x35) → no pulse, no state change. Then new_game with word_len = 0 → ignored. new_game asserted during CHECK with word "dog" → revealed = 0, miss_count = 0, WAIT_GUESS.
6. reset asserted while in UPDATE → next cycle all outputs 0, state IDLE, guess_ready = 0.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared constants, state encoding and letter helpers for the hangman round controller.
package hangman_pkg;

    localparam int MAX_LEN    = 10;
    localparam int CHAR_W     = 8;
    localparam int MAX_MISSES = 6;
    localparam int LEN_W      = 4;
    localparam int CNT_W      = 4;
    localparam int N_LETTERS  = 26;

    localparam logic [CHAR_W-1:0] CH_LOWER_A = 8'h61;
    localparam logic [CHAR_W-1:0] CH_LOWER_Z = 8'h7A;
    localparam logic [CHAR_W-1:0] CH_UPPER_A = 8'h41;
    localparam logic [CHAR_W-1:0] CH_UPPER_Z = 8'h5A;
    localparam logic [CHAR_W-1:0] CASE_OFFSET = 8'h20;

    localparam logic [CNT_W-1:0] MISS_LIMIT = CNT_W'(MAX_MISSES);
    localparam logic [LEN_W-1:0] LEN_LIMIT  = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GUESS,
        ST_CHECK,
        ST_UPDATE,
        ST_DONE
    } state_e;

    // Lowercase letter to alphabet index 0..25; callers only pass 'a'..'z'.
    function automatic logic [4:0] char_to_idx(input logic [CHAR_W-1:0] c);
        logic [CHAR_W-1:0] diff;
        diff = c - CH_LOWER_A;
        return diff[4:0];
    endfunction

endpackage

// File: rtl/letter_match.sv
// Per-slot comparator: flags every valid word slot holding the guessed letter.
module letter_match
    import hangman_pkg::*;
(
    input  logic [CHAR_W-1:0]         char_i,
    input  logic [MAX_LEN*CHAR_W-1:0] slots_i,
    input  logic [LEN_W-1:0]          len_i,
    output logic [MAX_LEN-1:0]        match_o,
    output logic                      any_o
);

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            match_o[i] = (slots_i[i*CHAR_W +: CHAR_W] == char_i) && (LEN_W'(i) < len_i);
        end
        any_o = |match_o;
    end

endmodule

// File: rtl/hangman_round_ctrl.sv
// Round controller: latches the word, screens guesses, tracks revealed slots and misses,
// and declares win or loss.
module hangman_round_ctrl
    import hangman_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_game,
    input  logic [MAX_LEN*CHAR_W-1:0] word_flat,
    input  logic [LEN_W-1:0]          word_len,
    input  logic                      guess_valid,
    input  logic [CHAR_W-1:0]         guess_char,
    output logic                      guess_ready,
    output logic [MAX_LEN-1:0]        revealed,
    output logic [CNT_W-1:0]          miss_count,
    output logic                      hit_pulse,
    output logic                      miss_pulse,
    output logic                      dup_pulse,
    output logic                      game_won,
    output logic                      game_lost
);

    state_e                      state_q, state_d;
    logic [MAX_LEN*CHAR_W-1:0]   word_q, word_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [N_LETTERS-1:0]        used_q, used_d;
    logic [CHAR_W-1:0]           char_q, char_d;
    logic [MAX_LEN-1:0]          match_q, match_d;
    logic                        any_q, any_d;
    logic [MAX_LEN-1:0]          revealed_q, revealed_d;
    logic [CNT_W-1:0]            miss_q, miss_d;
    logic                        hit_q, hit_d;
    logic                        missp_q, missp_d;
    logic                        dup_q, dup_d;
    logic                        won_q, won_d;
    logic                        lost_q, lost_d;

    logic [MAX_LEN-1:0]          lm_match;
    logic                        lm_any;
    logic [MAX_LEN-1:0]          len_mask;
    logic [CHAR_W-1:0]           folded;
    logic                        is_letter;
    logic [4:0]                  letter_idx;

    letter_match u_letter_match (
        .char_i  (char_q),
        .slots_i (word_q),
        .len_i   (len_q),
        .match_o (lm_match),
        .any_o   (lm_any)
    );

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        folded = guess_char;
        if (guess_char >= CH_UPPER_A && guess_char <= CH_UPPER_Z) begin
            folded = guess_char + CASE_OFFSET;
        end
        is_letter  = (folded >= CH_LOWER_A) && (folded <= CH_LOWER_Z);
        letter_idx = char_to_idx(folded);
    end

    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        len_d      = len_q;
        used_d     = used_q;
        char_d     = char_q;
        match_d    = match_q;
        any_d      = any_q;
        revealed_d = revealed_q;
        miss_d     = miss_q;
        won_d      = won_q;
        lost_d     = lost_q;
        hit_d      = 1'b0;
        missp_d    = 1'b0;
        dup_d      = 1'b0;

        if (new_game && word_len != '0) begin
            word_d     = word_flat;
            len_d      = (word_len > LEN_LIMIT) ? LEN_LIMIT : word_len;
            used_d     = '0;
            char_d     = '0;
            match_d    = '0;
            any_d      = 1'b0;
            revealed_d = '0;
            miss_d     = '0;
            won_d      = 1'b0;
            lost_d     = 1'b0;
            state_d    = ST_WAIT_GUESS;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_WAIT_GUESS: begin
                    if (guess_valid && is_letter) begin
                        if (used_q[letter_idx]) begin
                            dup_d = 1'b1;
                        end else begin
                            used_d[letter_idx] = 1'b1;
                            char_d             = folded;
                            state_d            = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    match_d = lm_match;
                    any_d   = lm_any;
                    state_d = ST_UPDATE;
                end
                ST_UPDATE: begin
                    revealed_d = revealed_q | match_q;
                    state_d    = ST_WAIT_GUESS;
                    if (!any_q) begin
                        missp_d = 1'b1;
                        miss_d  = (miss_q < MISS_LIMIT) ? miss_q + 1'b1 : miss_q;
                        if (miss_q + 1'b1 == MISS_LIMIT) begin
                            lost_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        hit_d = 1'b1;
                        if (&(revealed_q | match_q | ~len_mask)) begin
                            won_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            len_q      <= '0;
            used_q     <= '0;
            char_q     <= '0;
            match_q    <= '0;
            any_q      <= 1'b0;
            revealed_q <= '0;
            miss_q     <= '0;
            hit_q      <= 1'b0;
            missp_q    <= 1'b0;
            dup_q      <= 1'b0;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            len_q      <= len_d;
            used_q     <= used_d;
            char_q     <= char_d;
            match_q    <= match_d;
            any_q      <= any_d;
            revealed_q <= revealed_d;
            miss_q     <= miss_d;
            hit_q      <= hit_d;
            missp_q    <= missp_d;
            dup_q      <= dup_d;
            won_q      <= won_d;
            lost_q     <= lost_d;
        end
    end

    assign guess_ready = (state_q == ST_WAIT_GUESS);
    assign revealed    = revealed_q;
    assign miss_count  = miss_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = missp_q;
    assign dup_pulse   = dup_q;
    assign game_won    = won_q;
    assign game_lost   = lost_q;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Directed self-checking bench for hangman_round_ctrl with hand-computed expectations.
module tb_hangman_round_ctrl;
    import hangman_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      new_game;
    logic [MAX_LEN*CHAR_W-1:0] word_flat;
    logic [LEN_W-1:0]          word_len;
    logic                      guess_valid;
    logic [CHAR_W-1:0]         guess_char;
    logic                      guess_ready;
    logic [MAX_LEN-1:0]        revealed;
    logic [CNT_W-1:0]          miss_count;
    logic                      hit_pulse;
    logic                      miss_pulse;
    logic                      dup_pulse;
    logic                      game_won;
    logic                      game_lost;

    int tests = 0;
    int fails = 0;

    hangman_round_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .word_flat   (word_flat),
        .word_len    (word_len),
        .guess_valid (guess_valid),
        .guess_char  (guess_char),
        .guess_ready (guess_ready),
        .revealed    (revealed),
        .miss_count  (miss_count),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .dup_pulse   (dup_pulse),
        .game_won    (game_won),
        .game_lost   (game_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input string w, input logic [LEN_W-1:0] len);
        word_flat = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < w.len()) word_flat[i*CHAR_W +: CHAR_W] = w[i];
        end
        word_len = len;
    endtask

    task automatic start_game(input string w, input logic [LEN_W-1:0] len);
        load_word(w, len);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check({"start_ready_", w}, guess_ready, 1);
        check({"start_won_", w}, game_won, 0);
        check({"start_lost_", w}, game_lost, 0);
    endtask

    // Waits (bounded) for guess_ready, then offers one guess for exactly one edge.
    task automatic send(input logic [CHAR_W-1:0] ch);
        int n = 0;
        while (!guess_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", guess_ready, 1);
        guess_valid = 1'b1;
        guess_char  = ch;
        tick();
        guess_valid = 1'b0;
    endtask

    task automatic guess_full(input logic [CHAR_W-1:0] ch);
        send(ch);
        tick();
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        new_game    = 1'b0;
        word_flat   = '0;
        word_len    = '0;
        guess_valid = 1'b0;
        guess_char  = '0;
        tick();
        tick();
        check("rst_ready", guess_ready, 0);
        check("rst_revealed", revealed, 0);
        check("rst_miss", miss_count, 0);
        check("rst_pulses", {hit_pulse, miss_pulse, dup_pulse}, 0);
        check("rst_flags", {game_won, game_lost}, 0);
        reset = 1'b0;
        tick();
        check("idle_ready", guess_ready, 0);

        // 1: apple, guess 'p'
        start_game("apple", 4'd5);
        guess_full("p");
        check("t1_revealed", revealed, 5'b00110);
        check("t1_hit", hit_pulse, 1);
        check("t1_miss_pulse", miss_pulse, 0);
        check("t1_miss_count", miss_count, 0);
        check("t1_ready", guess_ready, 1);
        tick();
        check("t1_hit_one_cycle", hit_pulse, 0);

        // 2: apple, full win then ignored guess in DONE
        start_game("apple", 4'd5);
        check("t2_cleared", revealed, 0);
        guess_full("a");
        check("t2_rev_a", revealed, 5'b00001);
        guess_full("p");
        check("t2_rev_p", revealed, 5'b00111);
        guess_full("l");
        check("t2_rev_l", revealed, 5'b01111);
        check("t2_not_won_yet", game_won, 0);
        guess_full("e");
        check("t2_rev_e", revealed, 5'b11111);
        check("t2_won", game_won, 1);
        check("t2_lost", game_lost, 0);
        check("t2_ready_done", guess_ready, 0);
        guess_valid = 1'b1;
        guess_char  = "z";
        tick();
        guess_valid = 1'b0;
        tick();
        tick();
        check("t2_z_rev", revealed, 5'b11111);
        check("t2_z_miss", miss_count, 0);
        check("t2_z_pulses", {hit_pulse, miss_pulse, dup_pulse}, 0);
        check("t2_won_held", game_won, 1);

        // 3: cat, six misses
        start_game("cat", 4'd3);
        begin
            logic [CHAR_W-1:0] misses [6];
            misses = '{"x", "y", "q", "w", "v", "u"};
            for (int i = 0; i < 6; i++) begin
                guess_full(misses[i]);
                check($sformatf("t3_miss_count_%0d", i + 1), miss_count, i + 1);
                check($sformatf("t3_miss_pulse_%0d", i + 1), miss_pulse, 1);
                check($sformatf("t3_lost_%0d", i + 1), game_lost, (i == 5) ? 1 : 0);
            end
        end
        check("t3_won", game_won, 0);
        check("t3_ready", guess_ready, 0);
        guess_valid = 1'b1;
        guess_char  = "k";
        tick();
        guess_valid = 1'b0;
        tick();
        tick();
        check("t3_saturated", miss_count, 6);
        check("t3_no_pulse", miss_pulse, 0);

        // Slots at or beyond word_len never match: 'e' is slot 4 of "apple" with len 3
        start_game("apple", 4'd3);
        guess_full("e");
        check("len_guard_miss", miss_pulse, 1);
        check("len_guard_rev", revealed, 0);
        guess_full("a");
        guess_full("p");
        check("len_guard_win", game_won, 1);
        check("len_guard_rev_win", revealed, 5'b00111);

        // 4: cat, 'c' then 'C' duplicate
        start_game("cat", 4'd3);
        guess_full("c");
        check("t4_rev_c", revealed, 3'b001);
        send("C");
        check("t4_dup", dup_pulse, 1);
        check("t4_dup_ready", guess_ready, 1);
        tick();
        check("t4_dup_one_cycle", dup_pulse, 0);
        check("t4_miss", miss_count, 0);
        check("t4_rev", revealed, 3'b001);

        // 5: non-letter, zero-length new_game, new_game during CHECK
        send(8'h35);
        check("t5_digit_pulses", {hit_pulse, miss_pulse, dup_pulse}, 0);
        check("t5_digit_ready", guess_ready, 1);
        tick();
        tick();
        check("t5_digit_late_pulses", {hit_pulse, miss_pulse, dup_pulse}, 0);
        check("t5_digit_miss", miss_count, 0);
        load_word("dog", 4'd0);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check("t5_len0_rev", revealed, 3'b001);
        check("t5_len0_ready", guess_ready, 1);
        send("a");
        check("t5_in_check", guess_ready, 0);
        load_word("dog", 4'd3);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check("t5_abort_rev", revealed, 0);
        check("t5_abort_miss", miss_count, 0);
        check("t5_abort_ready", guess_ready, 1);
        tick();
        check("t5_abort_pulses", {hit_pulse, miss_pulse, dup_pulse}, 0);
        guess_full("o");
        check("t5_dog_o", revealed, 3'b010);
        check("t5_dog_hit", hit_pulse, 1);

        // 6: reset while in UPDATE
        start_game("cat", 4'd3);
        send("t");
        tick();
        reset = 1'b1;
        tick();
        check("t6_ready", guess_ready, 0);
        check("t6_rev", revealed, 0);
        check("t6_miss", miss_count, 0);
        check("t6_pulses", {hit_pulse, miss_pulse, dup_pulse}, 0);
        check("t6_flags", {game_won, game_lost}, 0);
        reset = 1'b0;
        tick();
        check("t6_idle", guess_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
